// File: rtl/ioctl_pkg.sv
// Shared definitions for the ioctl download bus player.
// Provides the FSM state type, the default address width and the
// well-known image index values used by the core-side decoders.
package ioctl_pkg;

   localparam int unsigned IOCTL_ADDR_W = 25;

   localparam logic [7:0] IOCTL_IDX_ROM   = 8'h00;
   localparam logic [7:0] IOCTL_IDX_NVRAM = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LATCH  = 3'd2,
      ST_WRITE  = 3'd3,
      ST_GAP    = 3'd4,
      ST_FINISH = 3'd5
   } ioctl_state_t;

endpackage

// File: rtl/ioctl_player_if.sv
// ioctl download bus as seen between a producer (data_io or the player)
// and the core's ROM/PROM write decoders.
//   ioctl_download : transfer in progress
//   ioctl_index    : image index, stable for the whole transfer
//   ioctl_wr       : one-cycle write strobe
//   ioctl_addr     : byte address, valid while ioctl_wr
//   ioctl_dout     : byte data, valid while ioctl_wr
interface ioctl_player_if #(
   parameter int unsigned ADDR_W = 25
) ();

   logic              ioctl_download;
   logic [7:0]        ioctl_index;
   logic              ioctl_wr;
   logic [ADDR_W-1:0] ioctl_addr;
   logic [7:0]        ioctl_dout;

   // Producer side
   modport master (
      output ioctl_download,
      output ioctl_index,
      output ioctl_wr,
      output ioctl_addr,
      output ioctl_dout
   );

   // Consumer side
   modport slave (
      input ioctl_download,
      input ioctl_index,
      input ioctl_wr,
      input ioctl_addr,
      input ioctl_dout
   );

endinterface

// File: rtl/ioctl_player.sv
// ioctl_player: replays a byte image from a synchronous source memory onto
// the ioctl download bus with data_io-compatible pacing.
// Ports:
//   clk_sys, reset_n       : clock, synchronous active-low reset
//   start_i                : transfer request (acted on only when idle)
//   index_i, length_i      : image index and byte count, captured on start
//   pause_i                : stall between bytes while high
//   src_rd_o, src_addr_o   : source read strobe and byte address
//   src_data_i             : source data, valid one cycle after src_rd_o
//   bus                    : ioctl download bus (master side)
//   busy_o                 : high whenever the FSM is not idle
//   done_o                 : one-cycle pulse when a transfer completes
module ioctl_player
   import ioctl_pkg::*;
#(
   parameter int unsigned ADDR_W = IOCTL_ADDR_W,
   parameter int unsigned GAP    = 2
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic [7:0]        index_i,
   input  logic [ADDR_W:0]   length_i,
   input  logic              pause_i,
   output logic              src_rd_o,
   output logic [ADDR_W-1:0] src_addr_o,
   input  logic [7:0]        src_data_i,
   output logic              busy_o,
   output logic              done_o,
   ioctl_player_if.master    bus
);

   localparam int unsigned LEN_W = ADDR_W + 1;
   // Gap counter reload: counts down to zero, so GAP cycles need GAP-1.
   localparam logic [3:0] GAP_LOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

   // FSM and datapath state
   ioctl_state_t      state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  byte_q, byte_d;
   logic [3:0]        gap_q, gap_d;
   logic [7:0]        idx_q, idx_d;
   logic [7:0]        dout_q, dout_d;

   // Request capture stage: start/index/length sampled on every edge
   logic              start_q;
   logic [7:0]        index_in_q;
   logic [LEN_W-1:0]  length_in_q;

   // Registered outputs
   logic              src_rd_q, src_rd_d;
   logic [ADDR_W-1:0] src_addr_q, src_addr_d;
   logic              dl_q, dl_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              last_c;

   // Current byte is the final one of the image; LEN_W bits so that a
   // full 2^ADDR_W image compares without wrapping.
   assign last_c = ((byte_q + LEN_W'(1)) == len_q);

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      byte_d  = byte_q;
      gap_d   = gap_q;
      idx_d   = idx_q;
      dout_d  = dout_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_q) begin
               len_d   = length_in_q;
               idx_d   = index_in_q;
               byte_d  = '0;
               state_d = (length_in_q == '0) ? ST_FINISH : ST_FETCH;
            end
         end

         ST_FETCH: begin
            state_d = ST_LATCH;
         end

         ST_LATCH: begin
            dout_d  = src_data_i;
            state_d = ST_WRITE;
         end

         ST_WRITE: begin
            gap_d = GAP_LOAD;
            // With no gap the pause decision is taken here; a paused
            // transfer parks in GAP with the counter already at zero.
            if (GAP != 0) begin
               state_d = ST_GAP;
            end else if (last_c) begin
               state_d = ST_FINISH;
            end else if (pause_i) begin
               state_d = ST_GAP;
            end else begin
               state_d = ST_FETCH;
               byte_d  = byte_q + LEN_W'(1);
            end
         end

         ST_GAP: begin
            if (gap_q != 4'd0) begin
               gap_d = gap_q - 4'd1;
            end else if (last_c) begin
               state_d = ST_FINISH;
            end else if (!pause_i) begin
               state_d = ST_FETCH;
               byte_d  = byte_q + LEN_W'(1);
            end
         end

         ST_FINISH: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered copies of the next-state decode so they
      // line up with the state they describe.
      src_rd_d   = (state_d == ST_FETCH);
      src_addr_d = (state_d == ST_FETCH) ? byte_d[ADDR_W-1:0] : src_addr_q;
      wr_d       = (state_d == ST_WRITE);
      addr_d     = byte_d[ADDR_W-1:0];
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_q == ST_FINISH);
      // A zero-length request passes through FINISH without raising download.
      dl_d       = (state_d inside {ST_FETCH, ST_LATCH, ST_WRITE, ST_GAP}) ||
                   ((state_d == ST_FINISH) && (len_d != '0));
   end

   // State, datapath and output registers
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         byte_q      <= '0;
         gap_q       <= 4'd0;
         idx_q       <= IOCTL_IDX_ROM;
         dout_q      <= 8'd0;
         start_q     <= 1'b0;
         index_in_q  <= 8'd0;
         length_in_q <= '0;
         src_rd_q    <= 1'b0;
         src_addr_q  <= '0;
         dl_q        <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         byte_q      <= byte_d;
         gap_q       <= gap_d;
         idx_q       <= idx_d;
         dout_q      <= dout_d;
         start_q     <= start_i;
         index_in_q  <= index_i;
         length_in_q <= length_i;
         src_rd_q    <= src_rd_d;
         src_addr_q  <= src_addr_d;
         dl_q        <= dl_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign src_rd_o           = src_rd_q;
   assign src_addr_o         = src_addr_q;
   assign busy_o             = busy_q;
   assign done_o             = done_q;
   assign bus.ioctl_download = dl_q;
   assign bus.ioctl_index    = idx_q;
   assign bus.ioctl_wr       = wr_q;
   assign bus.ioctl_addr     = addr_q;
   assign bus.ioctl_dout     = dout_q;

endmodule

// File: tb/tb_ioctl_player.sv
// Bench for ioctl_player: instance A (ADDR_W=25, GAP=2) and instance B
// (ADDR_W=3, GAP=0, small enough to exercise a full 2^ADDR_W image).
// A sink model records every write; expected write times, addresses,
// data and done timing come from the byte-period arithmetic.
module tb_ioctl_player;
   import ioctl_pkg::*;

   localparam int unsigned AW_A  = 25;
   localparam int unsigned GAP_A = 2;
   localparam int unsigned AW_B  = 3;
   localparam int unsigned GAP_B = 0;

   typedef struct packed {
      int          e;
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_rec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   int   edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   int tests_run = 0;
   int tests_failed = 0;

   // Instance A signals
   logic            a_start, a_pause, a_src_rd, a_busy, a_done;
   logic [7:0]      a_index, a_src_data;
   logic [AW_A:0]   a_length;
   logic [AW_A-1:0] a_src_addr;
   logic [7:0]      mem_a [256];
   ioctl_player_if #(.ADDR_W(AW_A)) a_bus ();

   // Instance B signals
   logic            b_start, b_pause, b_src_rd, b_busy, b_done;
   logic [7:0]      b_index, b_src_data;
   logic [AW_B:0]   b_length;
   logic [AW_B-1:0] b_src_addr;
   logic [7:0]      mem_b [8];
   ioctl_player_if #(.ADDR_W(AW_B)) b_bus ();

   ioctl_player #(.ADDR_W(AW_A), .GAP(GAP_A)) dut_a (
      .clk_sys(clk), .reset_n(reset_n), .start_i(a_start), .index_i(a_index),
      .length_i(a_length), .pause_i(a_pause), .src_rd_o(a_src_rd),
      .src_addr_o(a_src_addr), .src_data_i(a_src_data), .busy_o(a_busy),
      .done_o(a_done), .bus(a_bus));

   ioctl_player #(.ADDR_W(AW_B), .GAP(GAP_B)) dut_b (
      .clk_sys(clk), .reset_n(reset_n), .start_i(b_start), .index_i(b_index),
      .length_i(b_length), .pause_i(b_pause), .src_rd_o(b_src_rd),
      .src_addr_o(b_src_addr), .src_data_i(b_src_data), .busy_o(b_busy),
      .done_o(b_done), .bus(b_bus));

   // Registered source memories: data valid only in the cycle after a read.
   always @(posedge clk) a_src_data <= a_src_rd ? mem_a[a_src_addr[7:0]] : 8'($urandom);
   always @(posedge clk) b_src_data <= b_src_rd ? mem_b[b_src_addr] : 8'($urandom);

   // Sink models
   wr_rec_t    a_wr_q[$], b_wr_q[$];
   int         a_done_q[$], b_done_q[$];
   int         a_rd_cnt = 0, a_dl_cnt = 0, a_b2b = 0, a_idx_bad = 0;
   int         b_rd_cnt = 0, b_dl_cnt = 0, b_b2b = 0;
   logic       a_prev_wr = 1'b0, b_prev_wr = 1'b0;
   logic [7:0] a_exp_idx = 8'd0;

   always @(negedge clk) begin
      if (a_bus.ioctl_wr) a_wr_q.push_back(wr_rec_t'{e: edge_n, addr: 32'(a_bus.ioctl_addr), data: a_bus.ioctl_dout});
      if (a_bus.ioctl_wr && a_prev_wr) a_b2b <= a_b2b + 1;
      a_prev_wr <= a_bus.ioctl_wr;
      if (a_src_rd) a_rd_cnt <= a_rd_cnt + 1;
      if (a_done) a_done_q.push_back(edge_n);
      if (a_bus.ioctl_download) a_dl_cnt <= a_dl_cnt + 1;
      if (a_bus.ioctl_download && a_bus.ioctl_index != a_exp_idx) a_idx_bad <= a_idx_bad + 1;
   end

   always @(negedge clk) begin
      if (b_bus.ioctl_wr) b_wr_q.push_back(wr_rec_t'{e: edge_n, addr: 32'(b_bus.ioctl_addr), data: b_bus.ioctl_dout});
      if (b_bus.ioctl_wr && b_prev_wr) b_b2b <= b_b2b + 1;
      b_prev_wr <= b_bus.ioctl_wr;
      if (b_src_rd) b_rd_cnt <= b_rd_cnt + 1;
      if (b_done) b_done_q.push_back(edge_n);
      if (b_bus.ioctl_download) b_dl_cnt <= b_dl_cnt + 1;
   end

   // Reference timing: first write 3 edges after the start edge, then one
   // write every 3+gap cycles; stalls push later bytes back.
   function automatic int exp_wr_edge(int k, int i, int gap, int stall_after, int stall);
      return k + 3 + i * (3 + gap) + ((i > stall_after) ? stall : 0);
   endfunction

   function automatic int exp_done_edge(int k, int n, int gap, int stall);
      return k + 2 + n * (3 + gap) + stall;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_a(input logic [7:0] idx, input logic [AW_A:0] len, output int k);
      a_index  = idx;
      a_length = len;
      a_start  = 1'b1;
      k = edge_n + 1;
      tick();
      a_start  = 1'b0;
      a_index  = 8'($urandom);
      a_length = (AW_A + 1)'($urandom);
   endtask

   task automatic start_b(input logic [AW_B:0] len, output int k);
      b_index  = 8'($urandom);
      b_length = len;
      b_start  = 1'b1;
      k = edge_n + 1;
      tick();
      b_start  = 1'b0;
      b_length = (AW_B + 1)'($urandom);
   endtask

   task automatic wait_done_a(input int n0, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         tick();
         if (a_done_q.size() > n0) ok = 1'b1;
      end
   endtask

   task automatic wait_done_b(input int n0, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         tick();
         if (b_done_q.size() > n0) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      logic [63:0] va, vb;
      reset_n = 1'b0;
      a_start = 1'b1; b_start = 1'b1;
      a_length = (AW_A + 1)'(7); b_length = (AW_B + 1)'(5);
      repeat (3) tick();
      va = 64'({a_src_rd, a_src_addr, a_bus.ioctl_download, a_bus.ioctl_index, a_bus.ioctl_wr,
                a_bus.ioctl_addr, a_bus.ioctl_dout, a_busy, a_done});
      vb = 64'({b_src_rd, b_src_addr, b_bus.ioctl_download, b_bus.ioctl_index, b_bus.ioctl_wr,
                b_bus.ioctl_addr, b_bus.ioctl_dout, b_busy, b_done});
      tests_run++;
      if (va !== 64'd0) begin tests_failed++; $display("FAIL reset_outputs_a: got %h want 0", va); end
      tests_run++;
      if (vb !== 64'd0) begin tests_failed++; $display("FAIL reset_outputs_b: got %h want 0", vb); end
      a_start = 1'b0; b_start = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (3) tick();
      tests_run++;
      if (a_busy !== 1'b0 || b_busy !== 1'b0 || a_done_q.size() != 0)
         begin tests_failed++; $display("FAIL reset_idle: busy a=%b b=%b dones=%0d want 0/0/0", a_busy, b_busy, a_done_q.size()); end
   endtask

   // Single transfer on A with full timing/data checks.
   task automatic run_check_a(input string name, input logic [7:0] idx, input int n);
      int k, d0, w0, r0, l0, b0, i0, exp_e; bit ok; wr_rec_t rec;
      d0 = a_done_q.size(); w0 = a_wr_q.size(); r0 = a_rd_cnt; l0 = a_dl_cnt; b0 = a_b2b; i0 = a_idx_bad;
      a_exp_idx = idx;
      start_a(idx, (AW_A + 1)'(n), k);
      wait_done_a(d0, 40 + n * 6, ok);
      repeat (4) tick();
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL %s_done_timeout: no done_o, want one", name); end
      tests_run++;
      if (a_wr_q.size() - w0 != n) begin tests_failed++; $display("FAIL %s_wr_count: got %0d want %0d", name, a_wr_q.size() - w0, n); end
      for (int i = 0; i < n && w0 + i < a_wr_q.size(); i++) begin
         rec = a_wr_q[w0 + i];
         exp_e = exp_wr_edge(k, i, GAP_A, n, 0);
         tests_run++;
         if (rec.e !== exp_e || rec.addr !== 32'(i) || rec.data !== mem_a[i])
            begin tests_failed++; $display("FAIL %s_wr%0d: got edge %0d addr %0h data %h want edge %0d addr %0h data %h",
                                           name, i, rec.e, rec.addr, rec.data, exp_e, i, mem_a[i]); end
      end
      tests_run++;
      if (a_done_q.size() - d0 != 1 || (a_done_q.size() > d0 && a_done_q[d0] != exp_done_edge(k, n, GAP_A, 0)))
         begin tests_failed++; $display("FAIL %s_done: got %0d pulses first at %0d want 1 at %0d", name,
                                        a_done_q.size() - d0, (a_done_q.size() > d0) ? a_done_q[d0] : -1, exp_done_edge(k, n, GAP_A, 0)); end
      tests_run++;
      if (a_dl_cnt - l0 != n * (3 + GAP_A) + 1 || a_rd_cnt - r0 != n)
         begin tests_failed++; $display("FAIL %s_dl_rd: got download %0d reads %0d want %0d %0d", name,
                                        a_dl_cnt - l0, a_rd_cnt - r0, n * (3 + GAP_A) + 1, n); end
      tests_run++;
      if (a_idx_bad - i0 != 0 || a_b2b - b0 != 0)
         begin tests_failed++; $display("FAIL %s_idx_b2b: got bad-index %0d b2b %0d want 0 0", name, a_idx_bad - i0, a_b2b - b0); end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 256; i++) mem_a[i] = 8'(8'hA0 + i);
      run_check_a("basic", 8'd5, 4);
   endtask

   task automatic test_random();
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < 256; i++) mem_a[i] = 8'($urandom);
         run_check_a("random", (t == 2) ? IOCTL_IDX_NVRAM : 8'($urandom), int'($urandom_range(1, 10)));
      end
   endtask

   // GAP=0 and full 2^ADDR_W image on instance B.
   task automatic run_check_b(input string name, input int n);
      int k, d0, w0, l0, b0, exp_e; bit ok; wr_rec_t rec;
      for (int i = 0; i < 8; i++) mem_b[i] = 8'($urandom);
      d0 = b_done_q.size(); w0 = b_wr_q.size(); l0 = b_dl_cnt; b0 = b_b2b;
      start_b((AW_B + 1)'(n), k);
      wait_done_b(d0, 40 + n * 4, ok);
      repeat (3) tick();
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL %s_done_timeout: no done_o, want one", name); end
      tests_run++;
      if (b_wr_q.size() - w0 != n) begin tests_failed++; $display("FAIL %s_wr_count: got %0d want %0d", name, b_wr_q.size() - w0, n); end
      for (int i = 0; i < n && w0 + i < b_wr_q.size(); i++) begin
         rec = b_wr_q[w0 + i];
         exp_e = exp_wr_edge(k, i, GAP_B, n, 0);
         tests_run++;
         if (rec.e !== exp_e || rec.addr !== 32'(i) || rec.data !== mem_b[i])
            begin tests_failed++; $display("FAIL %s_wr%0d: got edge %0d addr %0h data %h want edge %0d addr %0h data %h",
                                           name, i, rec.e, rec.addr, rec.data, exp_e, i, mem_b[i]); end
      end
      tests_run++;
      if (b_b2b - b0 != 0 || b_dl_cnt - l0 != n * (3 + GAP_B) + 1 ||
          b_done_q.size() - d0 != 1 || (b_done_q.size() > d0 && b_done_q[d0] != exp_done_edge(k, n, GAP_B, 0)))
         begin tests_failed++; $display("FAIL %s_timing: got b2b %0d download %0d dones %0d want 0 %0d 1 at %0d", name,
                                        b_b2b - b0, b_dl_cnt - l0, b_done_q.size() - d0, n * (3 + GAP_B) + 1, exp_done_edge(k, n, GAP_B, 0)); end
   endtask

   task automatic test_gap0();
      run_check_b("gap0", 3);
   endtask

   task automatic test_full_length();
      run_check_b("full", 1 << AW_B);
   endtask

   task automatic test_zero_len();
      int k, d0, w0, r0, l0;
      d0 = a_done_q.size(); w0 = a_wr_q.size(); r0 = a_rd_cnt; l0 = a_dl_cnt;
      start_a(8'd9, '0, k);
      repeat (8) tick();
      tests_run++;
      if (a_done_q.size() - d0 != 1 || (a_done_q.size() > d0 && a_done_q[d0] != k + 2))
         begin tests_failed++; $display("FAIL zero_done: got %0d pulses first at %0d want 1 at %0d",
                                        a_done_q.size() - d0, (a_done_q.size() > d0) ? a_done_q[d0] : -1, k + 2); end
      tests_run++;
      if (a_dl_cnt - l0 != 0 || a_rd_cnt - r0 != 0 || a_wr_q.size() - w0 != 0)
         begin tests_failed++; $display("FAIL zero_quiet: got download %0d reads %0d writes %0d want 0 0 0",
                                        a_dl_cnt - l0, a_rd_cnt - r0, a_wr_q.size() - w0); end
   endtask

   // Pause held for 10 cycles from the last gap cycle after byte 1.
   task automatic test_pause();
      int k, d0, w0, l0, exp_e; bit ok; wr_rec_t rec;
      for (int i = 0; i < 256; i++) mem_a[i] = 8'($urandom);
      d0 = a_done_q.size(); w0 = a_wr_q.size(); l0 = a_dl_cnt;
      a_exp_idx = 8'h42;
      start_a(8'h42, (AW_A + 1)'(4), k);
      while (edge_n < k + 5 + (3 + GAP_A)) tick();
      a_pause = 1'b1;
      repeat (10) tick();
      a_pause = 1'b0;
      wait_done_a(d0, 60, ok);
      repeat (3) tick();
      tests_run++;
      if (!ok || a_wr_q.size() - w0 != 4) begin tests_failed++; $display("FAIL pause_count: got done=%0b writes %0d want 1 4", ok, a_wr_q.size() - w0); end
      for (int i = 0; i < 4 && w0 + i < a_wr_q.size(); i++) begin
         rec = a_wr_q[w0 + i];
         exp_e = exp_wr_edge(k, i, GAP_A, 1, 10);
         tests_run++;
         if (rec.e !== exp_e || rec.addr !== 32'(i) || rec.data !== mem_a[i])
            begin tests_failed++; $display("FAIL pause_wr%0d: got edge %0d addr %0h data %h want edge %0d addr %0h data %h",
                                           i, rec.e, rec.addr, rec.data, exp_e, i, mem_a[i]); end
      end
      tests_run++;
      if (a_dl_cnt - l0 != 4 * (3 + GAP_A) + 1 + 10 || (a_done_q.size() > d0 && a_done_q[d0] != exp_done_edge(k, 4, GAP_A, 10)))
         begin tests_failed++; $display("FAIL pause_done: got download %0d done %0d want %0d %0d", a_dl_cnt - l0,
                                        (a_done_q.size() > d0) ? a_done_q[d0] : -1, 4 * (3 + GAP_A) + 11, exp_done_edge(k, 4, GAP_A, 10)); end
   endtask

   // Reset during the LATCH of byte 2, then a fresh transfer.
   task automatic test_reset_mid();
      int k, d0, w0; logic [63:0] va;
      for (int i = 0; i < 256; i++) mem_a[i] = 8'($urandom);
      d0 = a_done_q.size(); w0 = a_wr_q.size();
      a_exp_idx = 8'h17;
      start_a(8'h17, (AW_A + 1)'(4), k);
      while (edge_n < k + 2 + 2 * (3 + GAP_A)) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      va = 64'({a_src_rd, a_src_addr, a_bus.ioctl_download, a_bus.ioctl_index, a_bus.ioctl_wr,
                a_bus.ioctl_addr, a_bus.ioctl_dout, a_busy, a_done});
      tests_run++;
      if (va !== 64'd0) begin tests_failed++; $display("FAIL midreset_outputs: got %h want 0", va); end
      repeat (30) tick();
      tests_run++;
      if (a_done_q.size() - d0 != 0 || a_wr_q.size() - w0 != 2)
         begin tests_failed++; $display("FAIL midreset_aborted: got dones %0d writes %0d want 0 2", a_done_q.size() - d0, a_wr_q.size() - w0); end
      run_check_a("replay", 8'h18, 2);
   endtask

   // A second start mid-transfer must be ignored.
   task automatic test_restart_ignored();
      int k, d0, w0, i0; bit ok;
      for (int i = 0; i < 256; i++) mem_a[i] = 8'($urandom);
      d0 = a_done_q.size(); w0 = a_wr_q.size(); i0 = a_idx_bad;
      a_exp_idx = 8'h33;
      start_a(8'h33, (AW_A + 1)'(5), k);
      while (edge_n < k + 8) tick();
      a_index = 8'h77; a_length = (AW_A + 1)'(2); a_start = 1'b1;
      tick();
      a_start = 1'b0;
      wait_done_a(d0, 60, ok);
      repeat (30) tick();
      tests_run++;
      if (!ok || a_done_q.size() - d0 != 1 || a_done_q[d0] != exp_done_edge(k, 5, GAP_A, 0))
         begin tests_failed++; $display("FAIL restart_done: got %0d pulses first at %0d want 1 at %0d", a_done_q.size() - d0,
                                        (a_done_q.size() > d0) ? a_done_q[d0] : -1, exp_done_edge(k, 5, GAP_A, 0)); end
      tests_run++;
      if (a_wr_q.size() - w0 != 5 || a_idx_bad - i0 != 0 ||
          (a_wr_q.size() - w0 == 5 && (a_wr_q[w0 + 4].addr !== 32'd4 || a_wr_q[w0 + 4].data !== mem_a[4])))
         begin tests_failed++; $display("FAIL restart_stream: got writes %0d bad-index %0d want 5 0", a_wr_q.size() - w0, a_idx_bad - i0); end
   endtask

   initial begin
      reset_n = 1'b0;
      a_start = 1'b0; a_pause = 1'b0; a_index = 8'd0; a_length = '0;
      b_start = 1'b0; b_pause = 1'b0; b_index = 8'd0; b_length = '0;
      for (int i = 0; i < 256; i++) mem_a[i] = 8'd0;
      for (int i = 0; i < 8; i++) mem_b[i] = 8'd0;
      test_reset();
      test_basic();
      test_random();
      test_gap0();
      test_full_length();
      test_zero_len();
      test_pause();
      test_reset_mid();
      test_restart_ignored();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

endmodule
